div_iter: RTL and testbench

//  Iterative 32-cycle radix-2 restoring divider in EX for DIV/DIVU; writes hi/lo

---
 rtl/div_iter_if.sv | 28 ++
 rtl/div_iter.sv | 145 ++++++++++++++
 tb/tb_div_iter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// Every signal here is single-cycle combinational or registered at the divider.
// The master side is the pipeline; the slave side is the divider.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             annul;
  logic [WIDTH-1:0] opdata1;
  logic [WIDTH-1:0] opdata2;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             ready;
  logic             stallreq_for_div;

  // Pipeline side: issues operations, consumes results and the stall request.
  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  result_lo, result_hi, ready, stallreq_for_div
  );

  // Divider side.
  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output result_lo, result_hi, ready, stallreq_for_div
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU; quotient to lo, remainder to hi.
// Latency: 33 cycles from accepted start to the ready strobe (2 for divide-by-zero).
// Backpressure: holds stallreq_for_div high until the result cycle; annul aborts.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_BUSY    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  logic             accept;
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_mag, op2_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   dvs_ext;
  logic             ge;
  logic [WIDTH-1:0] iter_rem, iter_quo;

  // Operand magnitudes and one restoring step of the shift/subtract loop.
  always_comb begin
    accept   = bus.start & ~bus.annul;
    op1_neg  = bus.signed_div & bus.opdata1[WIDTH-1];
    op2_neg  = bus.signed_div & bus.opdata2[WIDTH-1];
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
    op1_mag  = op1_neg ? -bus.opdata1 : bus.opdata1;
    op2_mag  = op2_neg ? -bus.opdata2 : bus.opdata2;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    dvs_ext  = {1'b0, dvs_q};
    ge       = (shifted >= dvs_ext);
    // When ge holds the difference is below the divisor, so it fits WIDTH bits.
    iter_rem = ge ? WIDTH'(shifted - dvs_ext) : shifted[WIDTH-1:0];
    iter_quo = {quo_q[WIDTH-2:0], ge};
  end

  // Next-state, datapath updates and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.opdata2 == '0) begin
            state_d = ST_DIVZERO;
          end else begin
            state_d   = ST_BUSY;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = op1_mag;
            dvs_d     = op2_mag;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
          end
        end
      end
      ST_BUSY: begin
        if (bus.annul) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = iter_rem;
          quo_d = iter_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Final iteration: fix up signs straight into the result registers.
            state_d  = ST_DONE;
            res_lo_d = neg_quo_q ? -iter_quo : iter_quo;
            res_hi_d = neg_rem_q ? -iter_rem : iter_rem;
          end
        end
      end
      ST_DIVZERO: begin
        if (bus.annul) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_DONE;
          res_lo_d = '0;
          res_hi_d = '0;
        end
      end
      ST_DONE: begin
        // No back-to-back restart: the stalled instruction leaves EX this cycle.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    bus.ready            = (state_q == ST_DONE) & ~bus.annul;
    bus.stallreq_for_div = ((state_q == ST_IDLE) & accept) |
                           (state_q == ST_BUSY) | (state_q == ST_DIVZERO);
    bus.result_lo        = res_lo_q;
    bus.result_hi        = res_hi_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, stall, signed/unsigned results, annul, reset.
// Inputs are driven 1 ns after the rising edge and outputs sampled there too.
// Expected values are hand-computed constants.
module tb_div_iter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready with a bound, scrambling operands to prove they are latched.
  task automatic wait_ready(input int exp_lat, input string tag);
    int n = 0;
    bit seen = 0;
    bit stall_ok = 1;
    while (!seen && n < 60) begin
      step();
      n++;
      bus.opdata1 = $urandom;
      bus.opdata2 = $urandom;
      if (bus.ready) seen = 1;
      else if (!bus.stallreq_for_div) stall_ok = 0;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
    chk({tag, "_stall_done"}, {31'd0, bus.stallreq_for_div}, 32'd0);
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi,
                        input int lat, input string tag);
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    #1;
    chk({tag, "_stall_req"}, {31'd0, bus.stallreq_for_div}, 32'd1);
    wait_ready(lat, tag);
    chk({tag, "_lo"}, bus.result_lo, lo);
    chk({tag, "_hi"}, bus.result_hi, hi);
    bus.start = 1'b0;
    step();
    chk({tag, "_ready_once"}, {31'd0, bus.ready}, 32'd0);
  endtask

  initial begin
    bit any_ready;
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul      = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_lo", bus.result_lo, 32'd0);
    chk("rst_hi", bus.result_hi, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_stall", {31'd0, bus.stallreq_for_div}, 32'd0);

    run_op(1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          33, "divu_100_7");
    run_op(1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33, "div_m7_2");
    run_op(1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33, "div_7_m2");
    run_op(1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          33, "divu_max_1");
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          33, "div_ovf");
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   33, "divu_big");
    run_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   33, "div_m100_m7");
    run_op(1'b0, 32'd7,        32'd9,          32'd0,          32'd7,          33, "divu_7_9");
    run_op(1'b0, 32'd5,        32'd0,          32'd0,          32'd0,          2,  "divzero");

    // Annul after 10 busy cycles: no strobe, results keep the divide-by-zero values.
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    for (int i = 0; i < 11; i++) step();
    bus.annul = 1'b1;
    bus.start = 1'b0;
    step();
    bus.annul = 1'b0;
    chk("annul_stall", {31'd0, bus.stallreq_for_div}, 32'd0);
    any_ready = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ready) any_ready = 1;
    end
    chk("annul_no_ready", {31'd0, any_ready}, 32'd0);
    chk("annul_lo_kept", bus.result_lo, 32'd0);
    chk("annul_hi_kept", bus.result_hi, 32'd0);
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "divu_9_3");

    // annul beats start while idle.
    bus.opdata1 = 32'd20;
    bus.opdata2 = 32'd4;
    bus.start   = 1'b1;
    bus.annul   = 1'b1;
    #1;
    chk("idle_annul_stall", {31'd0, bus.stallreq_for_div}, 32'd0);
    any_ready = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ready) any_ready = 1;
    end
    chk("idle_annul_no_ready", {31'd0, any_ready}, 32'd0);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    step();

    // annul in the result cycle suppresses the strobe.
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd50;
    bus.opdata2    = 32'd5;
    bus.start      = 1'b1;
    wait_ready(33, "done_annul");
    bus.annul = 1'b1;
    #1;
    chk("done_annul_ready", {31'd0, bus.ready}, 32'd0);
    chk("done_annul_lo", bus.result_lo, 32'd10);
    bus.start = 1'b0;
    step();
    bus.annul = 1'b0;
    #1;
    chk("done_annul_after", {31'd0, bus.ready}, 32'd0);

    // Reset after 20 busy cycles with start held: outputs clear, new op runs in full.
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd100;
    bus.opdata2    = 32'd7;
    bus.start      = 1'b1;
    for (int i = 0; i < 21; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_lo", bus.result_lo, 32'd0);
    chk("midrst_hi", bus.result_hi, 32'd0);
    chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
    wait_ready(33, "after_rst");
    chk("after_rst_lo", bus.result_lo, 32'd14);
    chk("after_rst_hi", bus.result_hi, 32'd2);
    bus.start = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
